// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises rx, frames start/data/parity/stop bits on
// baud ticks from an external generator, and hands words to the host via valid/ready.
module uart_rx_ctrl #(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_EN   = 0,
   parameter int PARITY_ODD  = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic                 rx,
   input  logic                 baud_tick,
   output logic                 baud_en,
   output logic                 baud_restart,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   // state    | meaning
   // S_IDLE   | line idle, baud generator stopped, waiting for falling edge
   // S_START  | generator restarted, confirm start bit low at its centre
   // S_DATA   | shift DATA_BITS data bits in, LSB first
   // S_PARITY | sample parity bit and compute mismatch
   // S_STOP   | sample stop bit, deliver word or flag overrun
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   localparam bit         PAR_EN   = (PARITY_EN != 0);
   localparam bit         ODD_BIT  = (PARITY_ODD != 0);
   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   rx_s;
   logic                   rx_s_prev;
   logic                   fall_edge;
   state_t                 state;
   logic [3:0]             bit_cnt;
   logic [DATA_BITS-1:0]   shift;
   logic                   perr;

   assign rx_s      = sync[SYNC_STAGES-1];
   assign fall_edge = rx_s_prev & ~rx_s;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sync      <= '1;
         rx_s_prev <= 1'b1;
      end else begin
         sync      <= {sync[SYNC_STAGES-2:0], rx};
         rx_s_prev <= rx_s;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state        <= S_IDLE;
         bit_cnt      <= '0;
         shift        <= '0;
         perr         <= 1'b0;
         baud_en      <= 1'b0;
         baud_restart <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         frame_err    <= 1'b0;
         parity_err   <= 1'b0;
         overrun      <= 1'b0;
         busy         <= 1'b0;
      end else begin
         baud_restart <= 1'b0;
         overrun      <= 1'b0;
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;

         case (state)
            S_IDLE: begin
               if (fall_edge) begin
                  state        <= S_START;
                  baud_restart <= 1'b1;
                  baud_en      <= 1'b1;
                  busy         <= 1'b1;
               end
            end
            S_START: begin
               if (baud_tick) begin
                  if (!rx_s) begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                  end else begin
                     state   <= S_IDLE;
                     baud_en <= 1'b0;
                     busy    <= 1'b0;
                  end
               end
            end
            S_DATA: begin
               if (baud_tick) begin
                  shift   <= {rx_s, shift[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == LAST_BIT)
                     state <= PAR_EN ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               if (baud_tick) begin
                  perr  <= (^shift) ^ rx_s ^ ODD_BIT;
                  state <= S_STOP;
               end
            end
            S_STOP: begin
               if (baud_tick) begin
                  state   <= S_IDLE;
                  baud_en <= 1'b0;
                  busy    <= 1'b0;
                  // A word still waiting for the host wins; the new frame is dropped.
                  if (!rx_valid || rx_ready) begin
                     rx_data    <= shift;
                     frame_err  <= ~rx_s;
                     parity_err <= PAR_EN & perr;
                     rx_valid   <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end
            end
            default: begin
               state   <= S_IDLE;
               baud_en <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
